fsm_trans_handshake_ctrl: RTL

FSM_TRANS_HANDSHAKE_CTRL -- requirements
Module: fsm_trans_handshake_ctrl

---
 rtl/fsm_trans_pkg.sv | 22 ++
 rtl/fsm_trans_cell.sv | 69 ++++++
 rtl/fsm_trans_handshake_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/fsm_trans_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsm_trans_pkg                                                |
// | Description : Shared state encoding and default configuration constants    |
// |               for the transition handshake controller.                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package fsm_trans_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_ACK  = 2'd2
    } trans_state_e;

    localparam int          c_n_trans       = 8;
    localparam logic [7:0]  c_conflict_mask = 8'b0000_0110;
    localparam int          c_wdog_w        = 16;
    localparam logic [15:0] c_stall_limit   = 16'd1000;

endpackage
`default_nettype wire

// File: rtl/fsm_trans_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsm_trans_cell                                               |
// | Description : One transition's IDLE/FIRE/ACK 4-phase handshake FSM with    |
// |               registered fire, acknowledge and activity outputs.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fsm_trans_cell
    import fsm_trans_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic enable,
    input  logic grant,
    output logic t_fire,
    output logic ack,
    output logic active
);

    trans_state_e r_state;
    logic         r_fire;
    logic         r_ack;
    logic         r_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_fire   <= 1'b0;
            r_ack    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req && enable && grant) begin
                        r_state  <= ST_FIRE;
                        r_fire   <= 1'b1;
                        r_active <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    r_state <= ST_ACK;
                    r_fire  <= 1'b0;
                    r_ack   <= 1'b1;
                end
                // Holding req high here never re-fires; a low phase is required first.
                ST_ACK: begin
                    if (!req) begin
                        r_state  <= ST_IDLE;
                        r_ack    <= 1'b0;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_fire   <= 1'b0;
                    r_ack    <= 1'b0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign t_fire = r_fire;
    assign ack    = r_ack;
    assign active = r_active;

endmodule
`default_nettype wire

// File: rtl/fsm_trans_handshake_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsm_trans_handshake_ctrl                                     |
// | Description : N independent transition handshake FSMs with free-choice     |
// |               conflict arbitration; optional stall watchdog enabled by     |
// |               macro FSM_TRANS_STALL_WATCHDOG_EN.                           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fsm_trans_handshake_ctrl
    import fsm_trans_pkg::*;
#(
    parameter int                   N_TRANS       = c_n_trans,
    parameter logic [N_TRANS-1:0]   CONFLICT_MASK = N_TRANS'(c_conflict_mask),
    parameter logic [c_wdog_w-1:0]  STALL_LIMIT   = c_stall_limit
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_TRANS-1:0] req,
    input  logic [N_TRANS-1:0] enable,
    output logic [N_TRANS-1:0] t_fire,
    output logic [N_TRANS-1:0] ack,
    output logic               busy
`ifdef FSM_TRANS_STALL_WATCHDOG_EN
    ,
    output logic               stall
`endif
);

    logic [N_TRANS-1:0] w_active;
    logic [N_TRANS-1:0] w_cand;
    logic [N_TRANS-1:0] w_lowest;
    logic [N_TRANS-1:0] w_grant;
    logic               w_grp_firing;

    // Group members in ACK do not block; only a member in FIRE does.
    assign w_cand       = req & enable & ~w_active & CONFLICT_MASK;
    assign w_lowest     = w_cand & (~w_cand + {{(N_TRANS-1){1'b0}}, 1'b1});
    assign w_grp_firing = |(t_fire & CONFLICT_MASK);
    assign w_grant      = ~CONFLICT_MASK | (w_lowest & {N_TRANS{~w_grp_firing}});

    genvar gi;
    generate
        for (gi = 0; gi < N_TRANS; gi++) begin : g_cell
            fsm_trans_cell u_cell (
                .clk    (clk),
                .reset  (reset),
                .req    (req[gi]),
                .enable (enable[gi]),
                .grant  (w_grant[gi]),
                .t_fire (t_fire[gi]),
                .ack    (ack[gi]),
                .active (w_active[gi])
            );
        end
    endgenerate

    assign busy = |w_active;

`ifdef FSM_TRANS_STALL_WATCHDOG_EN
    logic [c_wdog_w-1:0] r_stall_cnt;
    logic                w_waiting;

    assign w_waiting = |(req & ~w_active);

    // Saturates rather than wrapping so a long stall never self-clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (|t_fire) begin
            r_stall_cnt <= '0;
        end else if (w_waiting && (r_stall_cnt != {c_wdog_w{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall = (r_stall_cnt >= STALL_LIMIT);
`else
    generate
        if (STALL_LIMIT == '0) begin : g_stall_limit_unused
        end
    endgenerate
`endif

endmodule
`default_nettype wire
